// File: rtl/mac_stream.sv
// rtl/mac_stream.sv - pipelined streaming multiply-accumulate with framed, handshaked results
module mac_stream #(
    parameter int A_W     = 8,
    parameter int B_W     = 8,
    parameter int ACC_W   = 22,
    parameter int MAX_LEN = 16,
    parameter int SIGNED  = 0,
    parameter int SAT     = 1,
    parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   a,
    input  logic [B_W-1:0]   b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] y,
    output logic [CNT_W-1:0] y_cnt,
    output logic             ovf
);

    localparam int P_W = A_W + B_W;
    localparam bit IS_S = (SIGNED != 0);
    localparam bit IS_SAT = (SAT != 0);
    localparam logic [CNT_W-1:0] LEN_C = CNT_W'(MAX_LEN);
    localparam logic [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic             run;
    logic             en, accept;
    logic [P_W-1:0]   a_x, b_x, prod_n, prod_r;
    logic [CNT_W-1:0] cnt, cnt_inc, cnt1;
    logic             last_n, last1, v1;
    logic             first, ovf_acc;
    logic [ACC_W-1:0] acc, base, res;
    logic [ACC_W:0]   base_x, term_x, sum;
    logic             ovf_now, ovf_tot;

    // run keeps in_ready low while reset is held and for the release cycle
    assign en       = ~out_valid | out_ready;
    assign in_ready = run & en;
    assign accept   = in_valid & in_ready;

    // Low P_W bits of the product of extended operands equal the exact product
    assign a_x     = IS_S ? {{B_W{a[A_W-1]}}, a} : {{B_W{1'b0}}, a};
    assign b_x     = IS_S ? {{A_W{b[B_W-1]}}, b} : {{A_W{1'b0}}, b};
    assign prod_n  = a_x * b_x;
    assign cnt_inc = cnt + CNT_W'(1);
    assign last_n  = in_last | (cnt_inc == LEN_C);

    assign base    = first ? '0 : acc;
    assign base_x  = {IS_S & base[ACC_W-1], base};
    assign term_x  = IS_S ? {{(ACC_W+1-P_W){prod_r[P_W-1]}}, prod_r}
                          : {{(ACC_W+1-P_W){1'b0}}, prod_r};
    assign sum     = base_x + term_x;
    assign ovf_now = IS_S ? ((base_x[ACC_W] == term_x[ACC_W]) && (sum[ACC_W-1] != base[ACC_W-1]))
                          : sum[ACC_W];
    assign ovf_tot = (first ? 1'b0 : ovf_acc) | ovf_now;

    always_comb begin
        res = sum[ACC_W-1:0];
        if (ovf_now && IS_SAT) begin
            if (IS_S) res = base[ACC_W-1] ? SMIN : SMAX;
            else      res = '1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run       <= 1'b0;
            v1        <= 1'b0;
            prod_r    <= '0;
            last1     <= 1'b0;
            cnt       <= '0;
            cnt1      <= '0;
            first     <= 1'b1;
            acc       <= '0;
            ovf_acc   <= 1'b0;
            out_valid <= 1'b0;
            y         <= '0;
            y_cnt     <= '0;
            ovf       <= 1'b0;
        end else if (clr) begin
            run       <= 1'b1;
            v1        <= 1'b0;
            cnt       <= '0;
            first     <= 1'b1;
            acc       <= '0;
            ovf_acc   <= 1'b0;
            out_valid <= 1'b0;
            y         <= '0;
            y_cnt     <= '0;
            ovf       <= 1'b0;
        end else begin
            run <= 1'b1;
            if (en) begin
                v1 <= accept;
                if (accept) begin
                    prod_r <= prod_n;
                    last1  <= last_n;
                    cnt1   <= cnt_inc;
                    cnt    <= last_n ? '0 : cnt_inc;
                end
                // A pending result was either absent or taken this cycle
                out_valid <= v1 & last1;
                if (v1) begin
                    acc     <= res;
                    ovf_acc <= ovf_tot;
                    first   <= last1;
                    if (last1) begin
                        y     <= res;
                        y_cnt <= cnt1;
                        ovf   <= ovf_tot;
                    end
                end
            end
        end
    end

endmodule
